if_fetch: RTL and testbench

- Instruction-fetch front end: owns the PC, drives the instruction-memory request interface, and presents if_pc/if_inst to the IF/ID pipeline register.
- Producer side of the IF/ID interface. It honours the same 6-bit stall vector and branch redirect that IF/ID consumes.
- It raises stallreq_o to the pipeline controller while an instruction is not yet available. The controller then stops stage 0 and bubbles IF/ID.

---
 rtl/if_fetch_pkg.sv | 27 ++
 rtl/if_fetch.sv | 136 +++++++++++++
 tb/tb_if_fetch.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_pkg.sv
// Shared constants and state encoding for the instruction-fetch front end.
package if_fetch_pkg;

    // Reset is active-low: this is the asserted level of rst.
    localparam logic RSTN_ENABLE = 1'b0;

    // Meaning of stall[0] as seen by the fetch stage.
    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    // Level of branch_flag_i that requests a redirect.
    localparam logic BRANCH = 1'b1;

    // Default bus widths and the all-zero instruction word (nop).
    localparam int          INST_ADDR_BUS_W = 32;
    localparam int          INST_BUS_W      = 32;
    localparam logic [31:0] ZERO_WORD       = 32'h0000_0000;

    // Fetch controller states.
    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_WAIT = 2'd1,
        FETCH_KILL = 2'd2,
        FETCH_HOLD = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/if_fetch.sv
// Instruction-fetch front end: owns the PC, issues instruction-memory
// requests and presents if_pc/if_inst to the IF/ID pipeline register.
// Optional build macro: FETCH_BYPASS_EN forwards an acknowledged
// instruction straight to if_inst in the ack cycle (1 instr/cycle).
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter int                ADDR_W   = INST_ADDR_BUS_W,
    parameter int                INST_W   = INST_BUS_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        stall,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_target_address_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_ack_i,
    input  logic [INST_W-1:0] mem_data_i,
    output logic [ADDR_W-1:0] if_pc,
    output logic [INST_W-1:0] if_inst,
    output logic              stallreq_o
);

    fetch_state_e      r_state;
    fetch_state_e      w_stateNext;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pcNext;
    logic [INST_W-1:0] r_inst;
    logic [INST_W-1:0] w_instNext;
    logic              r_valid;
    logic              w_validNext;

    logic [ADDR_W-1:0] w_pcPlus4;
    logic [ADDR_W-1:0] w_target;
    logic              w_stop;
    logic              w_branch;
    logic              w_unusedBits;

    // Sequential PC advance wraps naturally at 2^ADDR_W; redirect targets
    // drop their low two bits so the PC stays word-aligned.
    assign w_pcPlus4    = r_pc + ADDR_W'(4);
    assign w_target     = {branch_target_address_i[ADDR_W-1:2], 2'b00};
    assign w_stop       = (stall[0] == STOP);
    assign w_branch     = (branch_flag_i == BRANCH);
    assign w_unusedBits = ^{stall[5:1], branch_target_address_i[1:0]};

    // State, PC and captured-instruction registers; reset abandons any
    // outstanding request by returning to IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RSTN_ENABLE) begin
            r_state <= FETCH_IDLE;
            r_pc    <= RESET_PC;
            r_inst  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_pc    <= w_pcNext;
            r_inst  <= w_instNext;
            r_valid <= w_validNext;
        end
    end

    // Next-state logic: branch always wins, acks outside WAIT/KILL are ignored.
    always_comb begin
        w_stateNext = r_state;
        w_pcNext    = r_pc;
        w_instNext  = r_inst;
        w_validNext = r_valid;
        case (r_state)
            FETCH_IDLE: begin
                w_stateNext = FETCH_WAIT;
            end
            FETCH_WAIT: begin
                if (w_branch) begin
                    w_pcNext    = w_target;
                    w_stateNext = mem_ack_i ? FETCH_WAIT : FETCH_KILL;
                end else if (mem_ack_i) begin
`ifdef FETCH_BYPASS_EN
                    if (!w_stop) begin
                        w_pcNext    = w_pcPlus4;
                        w_stateNext = FETCH_WAIT;
                    end else begin
                        w_instNext  = mem_data_i;
                        w_validNext = 1'b1;
                        w_stateNext = FETCH_HOLD;
                    end
`else
                    w_instNext  = mem_data_i;
                    w_validNext = 1'b1;
                    w_stateNext = FETCH_HOLD;
`endif
                end
            end
            FETCH_KILL: begin
                if (w_branch) begin
                    w_pcNext = w_target;
                end
                if (mem_ack_i) begin
                    w_stateNext = FETCH_WAIT;
                end
            end
            FETCH_HOLD: begin
                if (w_branch) begin
                    w_pcNext    = w_target;
                    w_validNext = 1'b0;
                    w_stateNext = FETCH_WAIT;
                end else if (!w_stop) begin
                    w_pcNext    = w_pcPlus4;
                    w_validNext = 1'b0;
                    w_stateNext = FETCH_WAIT;
                end
            end
            default: begin
                w_stateNext = FETCH_IDLE;
            end
        endcase
    end

    // Output decode: request only in WAIT, instruction visible only when valid.
    always_comb begin
        mem_req_o  = (r_state == FETCH_WAIT);
        mem_addr_o = (r_state == FETCH_WAIT) ? r_pc : '0;
        if_pc      = r_pc;
        if_inst    = r_valid ? r_inst : '0;
        stallreq_o = (r_state != FETCH_HOLD);
`ifdef FETCH_BYPASS_EN
        if ((r_state == FETCH_WAIT) && mem_ack_i && !w_branch) begin
            if_inst    = mem_data_i;
            stallreq_o = 1'b0;
        end
`endif
    end

endmodule

// File: tb/tb_if_fetch.sv
// Directed self-checking bench for if_fetch (default build).
module tb_if_fetch;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        branch_flag_i;
    logic [31:0] branch_target_address_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_data_i;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        stallreq_o;

    int checks;
    int errors;

    if_fetch dut (
        .clk                     (clk),
        .rst                     (rst),
        .stall                   (stall),
        .branch_flag_i           (branch_flag_i),
        .branch_target_address_i (branch_target_address_i),
        .mem_req_o               (mem_req_o),
        .mem_addr_o              (mem_addr_o),
        .mem_ack_i               (mem_ack_i),
        .mem_data_i              (mem_data_i),
        .if_pc                   (if_pc),
        .if_inst                 (if_inst),
        .stallreq_o              (stallreq_o)
    );

    // Free-running clock, posedges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction word the memory returns for a given address.
    function automatic logic [31:0] instFor(input logic [31:0] addr);
        return addr ^ 32'h1300_0013;
    endfunction

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        stall = 6'b0;
        branch_flag_i = 1'b0;
        branch_target_address_i = 32'h0;
        mem_ack_i = 1'b0;
        mem_data_i = 32'h0;
        #1 rst = 1'b0;
        step();
        step();
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %b expected 0", mem_req_o); end
        checks++; if (mem_addr_o !== 32'h0) begin errors++; $display("[TB] FAIL reset_addr: got %h expected 0", mem_addr_o); end
        checks++; if (if_inst !== 32'h0) begin errors++; $display("[TB] FAIL reset_inst: got %h expected 0", if_inst); end
        checks++; if (if_pc !== 32'h0) begin errors++; $display("[TB] FAIL reset_pc: got %h expected 0", if_pc); end
        checks++; if (stallreq_o !== 1'b1) begin errors++; $display("[TB] FAIL reset_stallreq: got %b expected 1", stallreq_o); end
        rst = 1'b1;
        step();
    endtask

    task automatic test_zero_wait();
        logic [31:0] a;
        for (int i = 0; i < 3; i++) begin
            a = 32'(i * 4);
            checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== a) begin errors++; $display("[TB] FAIL zw_req%0d: got req=%b addr=%h expected req=1 addr=%h", i, mem_req_o, mem_addr_o, a); end
            checks++; if (if_inst !== 32'h0 || stallreq_o !== 1'b1) begin errors++; $display("[TB] FAIL zw_wait%0d: got inst=%h stallreq=%b expected inst=0 stallreq=1", i, if_inst, stallreq_o); end
            mem_ack_i = 1'b1;
            mem_data_i = instFor(a);
            step();
            mem_ack_i = 1'b0;
            checks++; if (if_inst !== instFor(a) || if_pc !== a || stallreq_o !== 1'b0 || mem_req_o !== 1'b0) begin errors++; $display("[TB] FAIL zw_hold%0d: got inst=%h pc=%h stallreq=%b req=%b expected inst=%h pc=%h stallreq=0 req=0", i, if_inst, if_pc, stallreq_o, mem_req_o, instFor(a), a); end
            step();
        end
    endtask

    task automatic test_wait_states();
        for (int k = 0; k < 3; k++) begin
            checks++; if (stallreq_o !== 1'b1 || mem_req_o !== 1'b1 || mem_addr_o !== 32'hC) begin errors++; $display("[TB] FAIL ws_wait%0d: got stallreq=%b req=%b addr=%h expected 1 1 0000000c", k, stallreq_o, mem_req_o, mem_addr_o); end
            step();
        end
        mem_ack_i = 1'b1;
        mem_data_i = instFor(32'hC);
        checks++; if (mem_addr_o !== 32'hC) begin errors++; $display("[TB] FAIL ws_ackaddr: got %h expected 0000000c", mem_addr_o); end
        step();
        mem_ack_i = 1'b0;
        checks++; if (if_inst !== instFor(32'hC) || stallreq_o !== 1'b0) begin errors++; $display("[TB] FAIL ws_hold: got inst=%h stallreq=%b expected inst=%h stallreq=0", if_inst, stallreq_o, instFor(32'hC)); end
        step();
    endtask

    task automatic test_stall_hold();
        mem_ack_i = 1'b1;
        mem_data_i = instFor(32'h10);
        step();
        mem_ack_i = 1'b0;
        stall = 6'b000001;
        for (int k = 0; k < 4; k++) begin
            checks++; if (if_pc !== 32'h10 || if_inst !== instFor(32'h10) || mem_req_o !== 1'b0 || stallreq_o !== 1'b0) begin errors++; $display("[TB] FAIL sh_hold%0d: got pc=%h inst=%h req=%b stallreq=%b expected pc=00000010 inst=%h req=0 stallreq=0", k, if_pc, if_inst, mem_req_o, stallreq_o, instFor(32'h10)); end
            if (k == 1) begin
                mem_ack_i = 1'b1;
                mem_data_i = 32'hBAD0_0BAD;
            end
            step();
            mem_ack_i = 1'b0;
        end
        stall = 6'b0;
        checks++; if (if_inst !== instFor(32'h10)) begin errors++; $display("[TB] FAIL sh_ignoredack: got %h expected %h", if_inst, instFor(32'h10)); end
        step();
        checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h14) begin errors++; $display("[TB] FAIL sh_next: got req=%b addr=%h expected req=1 addr=00000014", mem_req_o, mem_addr_o); end
    endtask

    task automatic test_branch_kill();
        branch_flag_i = 1'b1;
        branch_target_address_i = 32'h103;
        step();
        branch_flag_i = 1'b0;
        checks++; if (mem_req_o !== 1'b0 || stallreq_o !== 1'b1 || if_pc !== 32'h100 || if_inst !== 32'h0) begin errors++; $display("[TB] FAIL bk_kill: got req=%b stallreq=%b pc=%h inst=%h expected 0 1 00000100 0", mem_req_o, stallreq_o, if_pc, if_inst); end
        step();
        mem_ack_i = 1'b1;
        mem_data_i = 32'hBAD0_0BAD;
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("[TB] FAIL bk_killreq: got %b expected 0", mem_req_o); end
        step();
        mem_ack_i = 1'b0;
        checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h100 || if_inst !== 32'h0) begin errors++; $display("[TB] FAIL bk_reissue: got req=%b addr=%h inst=%h expected 1 00000100 0", mem_req_o, mem_addr_o, if_inst); end
        mem_ack_i = 1'b1;
        mem_data_i = instFor(32'h100);
        step();
        mem_ack_i = 1'b0;
        checks++; if (if_inst !== instFor(32'h100)) begin errors++; $display("[TB] FAIL bk_inst: got %h expected %h", if_inst, instFor(32'h100)); end
        step();
        checks++; if (mem_addr_o !== 32'h104) begin errors++; $display("[TB] FAIL bk_next: got %h expected 00000104", mem_addr_o); end
    endtask

    task automatic test_branch_with_ack();
        branch_flag_i = 1'b1;
        branch_target_address_i = 32'h200;
        mem_ack_i = 1'b1;
        mem_data_i = 32'hBAD0_0BAD;
        step();
        branch_flag_i = 1'b0;
        mem_ack_i = 1'b0;
        checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h200 || if_inst !== 32'h0 || stallreq_o !== 1'b1) begin errors++; $display("[TB] FAIL ba_wait: got req=%b addr=%h inst=%h stallreq=%b expected 1 00000200 0 1", mem_req_o, mem_addr_o, if_inst, stallreq_o); end
        mem_ack_i = 1'b1;
        mem_data_i = instFor(32'h200);
        step();
        mem_ack_i = 1'b0;
        checks++; if (if_inst !== instFor(32'h200)) begin errors++; $display("[TB] FAIL ba_hold: got %h expected %h", if_inst, instFor(32'h200)); end
        branch_flag_i = 1'b1;
        branch_target_address_i = 32'hFFFF_FFFF;
        stall = 6'b000001;
        step();
        branch_flag_i = 1'b0;
        stall = 6'b0;
        checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'hFFFF_FFFC || if_inst !== 32'h0) begin errors++; $display("[TB] FAIL ba_holdbranch: got req=%b addr=%h inst=%h expected 1 fffffffc 0", mem_req_o, mem_addr_o, if_inst); end
    endtask

    task automatic test_wrap();
        mem_ack_i = 1'b1;
        mem_data_i = instFor(32'hFFFF_FFFC);
        step();
        mem_ack_i = 1'b0;
        checks++; if (if_pc !== 32'hFFFF_FFFC || if_inst !== instFor(32'hFFFF_FFFC)) begin errors++; $display("[TB] FAIL wr_hold: got pc=%h inst=%h expected fffffffc %h", if_pc, if_inst, instFor(32'hFFFF_FFFC)); end
        step();
        checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0 || if_pc !== 32'h0) begin errors++; $display("[TB] FAIL wr_next: got req=%b addr=%h pc=%h expected 1 0 0", mem_req_o, mem_addr_o, if_pc); end
    endtask

    task automatic test_async_reset();
        mem_ack_i = 1'b1;
        mem_data_i = instFor(32'h0);
        step();
        mem_ack_i = 1'b0;
        step();
        checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h4) begin errors++; $display("[TB] FAIL ar_pre: got req=%b addr=%h expected 1 00000004", mem_req_o, mem_addr_o); end
        #3 rst = 1'b0;
        #1;
        checks++; if (mem_req_o !== 1'b0 || mem_addr_o !== 32'h0 || if_pc !== 32'h0 || stallreq_o !== 1'b1 || if_inst !== 32'h0) begin errors++; $display("[TB] FAIL ar_async: got req=%b addr=%h pc=%h stallreq=%b inst=%h expected 0 0 0 1 0", mem_req_o, mem_addr_o, if_pc, stallreq_o, if_inst); end
        #2 rst = 1'b1;
        mem_ack_i = 1'b1;
        mem_data_i = 32'hBAD0_0BAD;
        #1;
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("[TB] FAIL ar_idle: got %b expected 0", mem_req_o); end
        step();
        mem_ack_i = 1'b0;
        checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0 || if_inst !== 32'h0) begin errors++; $display("[TB] FAIL ar_restart: got req=%b addr=%h inst=%h expected 1 0 0", mem_req_o, mem_addr_o, if_inst); end
    endtask

    // Run every scenario in order; each leaves the fetch unit in a known state.
    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_stall_hold();
        test_branch_kill();
        test_branch_with_ack();
        test_wrap();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
